// File: rtl/audio_pkg.sv
// Shared I2S frame constants and elaboration-time parameter checks
// for the pedal output stage.
package audio_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 24;
    localparam int unsigned DEF_SLOT_WIDTH = 32;
    localparam int unsigned DEF_CLK_DIV    = 4;
    localparam int unsigned I2S_CHANNELS   = 2;
    localparam int unsigned MIN_CLK_DIV    = 2;

    // The MSB sits one SCK after the ws edge, so a sample needs a spare bit in its slot.
    function automatic bit data_fits_slot(input int unsigned dw, input int unsigned sw);
        return (dw >= 1) && (dw < sw);
    endfunction

    function automatic bit clk_div_ok(input int unsigned cd);
        return cd >= MIN_CLK_DIV;
    endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Mono sample stream from the effect chain: data plus a one-cycle valid
// strobe, no backpressure.
interface i2s_tx_if
    import audio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] data;
    logic                  vld;

    modport master (output data, output vld);
    modport slave  (input  data, input  vld);
endinterface

// File: rtl/i2s_sck_gen.sv
// Bit-clock divider: toggles sck every CLK_DIV clk cycles and flags the
// rise/fall events in the cycle the sck register toggles.
module i2s_sck_gen
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div;
    logic          term;

    assign term = en && (div == DIV_LAST);
    assign rise = term && !sck;
    assign fall = term && sck;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            div <= '0;
            sck <= 1'b0;
        end else if (term) begin
            div <= '0;
            sck <= ~sck;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one mono sample per frame, sent on both slots,
// through a single-entry holding register with overrun/underrun pulses.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned SLOT_WIDTH = DEF_SLOT_WIDTH,
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    i2s_tx_if.slave  smp,
    output logic     sck,
    output logic     ws,
    output logic     sd,
    output logic     underrun_o,
    output logic     overrun_o
);
    localparam int unsigned FRAME_BITS = I2S_CHANNELS * SLOT_WIDTH;
    localparam int unsigned BW         = $clog2(FRAME_BITS);
    localparam logic [BW-1:0] B_LAST   = BW'(FRAME_BITS - 1);

    if (!data_fits_slot(DATA_WIDTH, SLOT_WIDTH)) begin : g_bad_width
        $error("i2s_tx: DATA_WIDTH must be below SLOT_WIDTH");
    end
    if (!clk_div_ok(CLK_DIV)) begin : g_bad_div
        $error("i2s_tx: CLK_DIV must be at least 2");
    end

    logic                  rise;
    logic                  fall;
    logic [BW-1:0]         b;
    logic [BW-1:0]         b_next;
    int unsigned           p_next;
    logic                  frame_start;
    logic                  ws_next;
    logic                  sd_next;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0] hold;
    logic                  full;

    i2s_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .sck  (sck),
        .rise (rise),
        .fall (fall)
    );

    always_comb begin
        frame_start = fall && (b == B_LAST);
        b_next      = (b == B_LAST) ? '0 : b + 1'b1;
        p_next      = 32'(b_next) % SLOT_WIDTH;
        ws_next     = 32'(b_next) >= SLOT_WIDTH;
        // cur at a frame start is still the old sample, but p is 0 there so sd is 0 anyway.
        shifted     = cur << (p_next - 32'd1);
        sd_next     = 1'b0;
        if (p_next >= 1 && p_next <= DATA_WIDTH) begin
            sd_next = shifted[DATA_WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b  <= B_LAST;
            ws <= 1'b0;
            sd <= 1'b0;
        end else if (!en) begin
            b  <= B_LAST;
            ws <= 1'b0;
            sd <= 1'b0;
        end else if (fall) begin
            b  <= b_next;
            ws <= ws_next;
            sd <= sd_next;
        end
    end

    // A strobe in the frame-start cycle refills hold after cur has taken the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur        <= '0;
            hold       <= '0;
            full       <= 1'b0;
            underrun_o <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            underrun_o <= frame_start && !full;
            overrun_o  <= smp.vld && full && !frame_start;
            if (frame_start && full) begin
                cur <= hold;
            end
            if (smp.vld) begin
                hold <= smp.data;
                full <= 1'b1;
            end else if (frame_start) begin
                full <= 1'b0;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst) !(rise && fall));

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized bench for i2s_tx: a frame-level reference model derived from
// cycle counts and a one-deep sample queue, plus directed word captures.
module tb_i2s_tx;
    localparam int DW    = 24;
    localparam int SW    = 32;
    localparam int CD    = 4;
    localparam int FRAME = 2 * SW;

    logic clk;
    logic rst;
    logic en;
    logic sck, ws, sd, underrun_o, overrun_o;

    i2s_tx_if #(.DATA_WIDTH(DW)) smp ();

    i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .CLK_DIV(CD)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .smp        (smp),
        .sck        (sck),
        .ws         (ws),
        .sd         (sd),
        .underrun_o (underrun_o),
        .overrun_o  (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          ncyc;
    logic [23:0] cur_m;
    logic [23:0] q[$];
    bit          und_m, ovr_m, fs_last, rise_last;

    // observation state
    logic [23:0] shreg;
    logic [23:0] words[$];
    int          n_und, n_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        ncyc  = 0;
        cur_m = '0;
        q.delete();
        und_m = 0;
        ovr_m = 0;
        fs_last   = 0;
        rise_last = 0;
    endtask

    function automatic int cur_b();
        int f;
        f = ncyc / (2 * CD);
        return (f == 0) ? FRAME - 1 : (f - 1) % FRAME;
    endfunction

    function automatic bit next_is_fs();
        int n;
        n = ncyc + 1;
        return (n % (2 * CD) == 0) && (((n / (2 * CD)) - 1) % FRAME == 0);
    endfunction

    task automatic model_edge();
        int f;
        und_m = 0; ovr_m = 0; fs_last = 0; rise_last = 0;
        if (!rst) begin
            reset_model();
            return;
        end
        if (en) ncyc++; else ncyc = 0;
        if (en && ncyc % (2 * CD) == CD) rise_last = 1;
        if (en && ncyc % (2 * CD) == 0) begin
            f = ncyc / (2 * CD);
            if ((f - 1) % FRAME == 0) fs_last = 1;
        end
        if (fs_last) begin
            if (q.size() > 0) cur_m = q.pop_front();
            else und_m = 1;
        end
        if (smp.vld) begin
            if (q.size() > 0) begin
                ovr_m = 1;
                q.delete();
            end
            q.push_back(smp.data);
        end
    endtask

    task automatic compare_all();
        int f, b, p;
        logic [23:0] t;
        bit sck_e, ws_e, sd_e;
        sck_e = ((ncyc / CD) % 2) == 1;
        f = ncyc / (2 * CD);
        ws_e = 0; sd_e = 0; p = 0;
        if (f > 0) begin
            b = (f - 1) % FRAME;
            ws_e = b >= SW;
            p = b % SW;
            if (p >= 1 && p <= DW) begin
                t = cur_m >> (DW - p);
                sd_e = t[0];
            end
        end
        check("sck", sck, sck_e);
        check("ws", ws, ws_e);
        check("sd", sd, sd_e);
        check("underrun", underrun_o, und_m);
        check("overrun", overrun_o, ovr_m);
        if (underrun_o) n_und++;
        if (overrun_o) n_ovr++;
        if (rise_last && f > 0 && p >= 1 && p <= DW) begin
            shreg = {shreg[22:0], sd};
            if (p == DW) words.push_back(shreg);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        smp.data = 24'($urandom);
        smp.vld  = 1'b0;
    endtask

    task automatic send(input logic [23:0] d);
        smp.data = d;
        smp.vld  = 1'b1;
        step();
    endtask

    task automatic run_to_fs();
        bit hit;
        hit = 0;
        for (int i = 0; i < 1200 && !hit; i++) begin
            step();
            if (fs_last) hit = 1;
        end
        if (!hit) check("fs_timeout", 0, 1);
    endtask

    task automatic cycles_to_sck_high(output int n);
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            step();
            if (sck) n = i;
        end
    endtask

    task automatic check_words(input string tag, input logic [23:0] w, input int cnt);
        check({tag, "_count"}, words.size(), cnt);
        foreach (words[i]) check(tag, words[i], w);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        en  = 1'b1;
        smp.data = '0;
        smp.vld  = 1'b0;
        shreg = '0;
        n_und = 0; n_ovr = 0;
        reset_model();

        // reset held with activity on the inputs
        for (int i = 0; i < 5; i++) begin
            smp.vld = 1'($urandom);
            smp.data = 24'($urandom);
            step();
        end
        rst = 1'b1;
        cycles_to_sck_high(n);
        check("first_rise", n, 4);
        n = 4;
        for (int i = 0; i < 20 && underrun_o !== 1'b1; i++) begin
            step();
            n++;
        end
        check("first_fall_underrun", n, 8);

        // framing
        send(24'hA50F3C);
        run_to_fs();
        words.delete();
        run_to_fs();
        check_words("frame_word", 24'hA50F3C, 2);

        // underrun: one sample, then three empty frames
        send(24'h000001);
        run_to_fs();
        n_und = 0;
        words.delete();
        for (int i = 0; i < 3; i++) run_to_fs();
        check("underrun_pulses", n_und, 3);
        check_words("underrun_word", 24'h000001, 6);

        // overrun within one frame
        n_ovr = 0;
        repeat (20) step();
        send(24'h111111);
        repeat (30) step();
        send(24'h222222);
        run_to_fs();
        words.delete();
        run_to_fs();
        check("overrun_pulses", n_ovr, 1);
        check_words("overrun_word", 24'h222222, 2);

        // strobe coinciding with frame start while hold is full
        n_ovr = 0;
        repeat (40) step();
        send(24'h123456);
        for (int i = 0; i < 1200 && !next_is_fs(); i++) step();
        send(24'hABCDEF);
        check("coincident_fs", fs_last, 1);
        words.delete();
        run_to_fs();
        check_words("coincident_old", 24'h123456, 2);
        words.delete();
        run_to_fs();
        check_words("coincident_new", 24'hABCDEF, 2);
        check("coincident_overrun", n_ovr, 0);

        // asynchronous reset at b=10
        for (int i = 0; i < 1200 && cur_b() != 10; i++) step();
        check("reached_b10", cur_b(), 10);
        rst = 1'b0;
        reset_model();
        #1;
        compare_all();
        check("rst_sck", sck, 0);
        check("rst_ws", ws, 0);
        check("rst_sd", sd, 0);
        repeat (3) step();
        rst = 1'b1;
        cycles_to_sck_high(n);
        check("rst_rerise", n, 4);

        // enable drop mid-frame keeps cur
        send(24'h5A5A5A);
        run_to_fs();
        repeat (100) step();
        en = 1'b0;
        repeat (20) step();
        en = 1'b1;
        cycles_to_sck_high(n);
        check("en_rerise", n, 4);
        run_to_fs();
        words.delete();
        run_to_fs();
        check_words("en_keep_cur", 24'h5A5A5A, 2);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(5, 30)) step();
                en = 1'b1;
            end
            if (i == 2500) begin
                rst = 1'b0;
                reset_model();
                #1;
                compare_all();
                step();
                rst = 1'b1;
            end
            smp.vld  = ($urandom_range(0, 199) == 0);
            smp.data = 24'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
